// File: rtl/pong_game_ctrl_pkg.sv
// Shared definitions for the pong match controller and its neighbours:
// state encodings, winner codes and small elaboration-time helpers.
package pong_game_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_POINT = 3'd3,
        ST_OVER  = 3'd4
    } game_state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pong_frame_timer.sv
// Frame countdown: loads a value, decrements on each frame tick and flags
// the tick that takes it from 1 to 0 with a single-cycle expire pulse.
module pong_frame_timer #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         tick,
    output logic         expire
);

    logic [W-1:0] count;

    // A load wins over a coincident tick, so a freshly loaded value is never
    // shortened by the frame edge that arrives with the state entry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign expire = tick && (count == W'(1));

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: serve delay, rally, point pause and game over,
// with score keeping and ball hold/serve direction control.
module pong_game_ctrl
    import pong_game_ctrl_pkg::*;
#(
    parameter int WIN_SCORE    = 7,
    parameter int SERVE_FRAMES = 60,
    parameter int POINT_FRAMES = 90,
    parameter int SCORE_W      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               start_btn,
    input  logic               miss_left,
    input  logic               miss_right,
    output logic               ball_hold,
    output logic               serve_dir,
    output logic [SCORE_W-1:0] score_p1,
    output logic [SCORE_W-1:0] score_p2,
    output logic [1:0]         winner,
    output logic [2:0]         state_o
);

    localparam int TIMER_W = $clog2(max_int(SERVE_FRAMES, POINT_FRAMES) + 1);
    localparam logic [TIMER_W-1:0] SERVE_LOAD = TIMER_W'(SERVE_FRAMES);
    localparam logic [TIMER_W-1:0] POINT_LOAD = TIMER_W'(POINT_FRAMES);
    localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

    game_state_t        state;
    logic               vsync_q;
    logic               start_q;
    logic               frame_tick;
    logic               start_rise;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_val;
    logic               timer_expire;
    logic [SCORE_W-1:0] p1_next;
    logic [SCORE_W-1:0] p2_next;
    logic               single_miss;
    logic               match_point;

    assign frame_tick  = vsync_q & ~vsync;
    assign start_rise  = start_btn & ~start_q;
    assign p1_next     = score_p1 + SCORE_W'(1);
    assign p2_next     = score_p2 + SCORE_W'(1);
    assign single_miss = miss_left ^ miss_right;
    assign match_point = single_miss && (miss_left ? (p2_next == WIN_VAL)
                                                   : (p1_next == WIN_VAL));
    assign state_o     = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vsync_q   <= 1'b0;
            start_q   <= 1'b0;
            ball_hold <= 1'b1;
        end else begin
            vsync_q   <= vsync;
            start_q   <= start_btn;
            ball_hold <= (state != ST_PLAY);
        end
    end

    // Every state entry that starts a countdown reloads the timer here.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = SERVE_LOAD;
        unique case (state)
            ST_IDLE, ST_OVER: timer_load = start_rise;
            ST_PLAY: begin
                timer_load = (miss_left | miss_right) && !match_point;
                timer_val  = POINT_LOAD;
            end
            ST_POINT: timer_load = timer_expire;
            default: ;
        endcase
    end

    pong_frame_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (timer_load),
        .load_val (timer_val),
        .tick     (frame_tick),
        .expire   (timer_expire)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            serve_dir <= 1'b0;
            score_p1  <= '0;
            score_p2  <= '0;
            winner    <= WIN_NONE;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start_rise) begin
                        state    <= ST_SERVE;
                        score_p1 <= '0;
                        score_p2 <= '0;
                        winner   <= WIN_NONE;
                    end
                end
                ST_SERVE: begin
                    if (timer_expire) state <= ST_PLAY;
                end
                ST_PLAY: begin
                    // The next serve goes toward whoever just lost the point.
                    if (single_miss && miss_left) begin
                        score_p2  <= p2_next;
                        serve_dir <= 1'b0;
                    end else if (single_miss) begin
                        score_p1  <= p1_next;
                        serve_dir <= 1'b1;
                    end
                    if (match_point) begin
                        state  <= ST_OVER;
                        winner <= miss_left ? WIN_P2 : WIN_P1;
                    end else if (miss_left | miss_right) begin
                        state <= ST_POINT;
                    end
                end
                ST_POINT: begin
                    if (timer_expire) state <= ST_SERVE;
                end
                ST_OVER: begin
                    if (start_rise) begin
                        state     <= ST_SERVE;
                        score_p1  <= '0;
                        score_p2  <= '0;
                        winner    <= WIN_NONE;
                        serve_dir <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
